// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e  : access FSM states
//   F3_*         : funct3 size/sign encodings
//   STRB_*       : base byte-enable patterns before lane shifting
//   f3_legal     : funct3 legality (stores have no unsigned forms)
//   f3_aligned   : natural-alignment check for the access size
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return !lo[0];
      F3_W:        return (lo == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   st_funct3_i/st_lo_i/st_data_i : store size, address[1:0], right-aligned data
//   st_data_o/st_strb_o           : data shifted onto its byte lanes, byte enables
//   ld_funct3_i/ld_lo_i/ld_raw_i  : load size/sign, address[1:0], raw memory word
//   ld_data_o                     : extracted and sign/zero-extended load value
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_strb_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_lo_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  logic [4:0]         st_sh;
  logic [4:0]         ld_sh;
  logic [31:0]        ld_shifted;
  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;

  always_comb begin
    st_sh     = {st_lo_i, 3'b000};
    st_data_o = st_data_i << st_sh;
    case (st_funct3_i)
      F3_B:    st_strb_o = STRB_B << st_lo_i;
      F3_H:    st_strb_o = STRB_H << st_lo_i;
      default: st_strb_o = STRB_W;
    endcase
  end

  always_comb begin
    ld_sh      = {ld_lo_i, 3'b000};
    ld_shifted = ld_raw_i >> ld_sh;
    ld_b       = ld_shifted[7:0];
    ld_h       = ld_shifted[15:0];
    case (ld_funct3_i)
      // Size casts of signed operands replicate the sign bit.
      F3_B:    ld_data_o = 32'(ld_b);
      F3_H:    ld_data_o = 32'(ld_h);
      F3_BU:   ld_data_o = {24'h000000, ld_shifted[7:0]};
      F3_HU:   ld_data_o = {16'h0000, ld_shifted[15:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator for a single-cycle core. Turns mem_re/mem_we plus
// address and store data into a valid/ready request, waits for read data,
// and returns the extended load value for one cycle with done.
//   clk, rst                  : clock, synchronous active-high reset
//   mem_re, mem_we, funct3    : access request from the core (sampled in IDLE)
//   addr, wdata               : byte address and right-aligned store data
//   rdata, done               : load result, one-cycle completion pulse
//   stall                     : hold the core while an access is in flight
//   misalign_err, bus_err     : error pulses accompanying done
//   req_* / req_ready         : request channel to memory
//   rsp_valid, rsp_rdata      : read response channel from memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        bus_q, bus_d;

  logic [31:0] st_lane_data;
  logic [3:0]  st_lane_strb;
  logic [31:0] ld_ext;
  logic        access_ok;

  lsu_align u_align (
    .st_funct3_i (funct3),
    .st_lo_i     (addr[1:0]),
    .st_data_i   (wdata),
    .st_data_o   (st_lane_data),
    .st_strb_o   (st_lane_strb),
    .ld_funct3_i (f3_q),
    .ld_lo_i     (lo_q),
    .ld_raw_i    (rsp_rdata),
    .ld_data_o   (ld_ext)
  );

  // Store takes priority when both strobes are set.
  assign access_ok = f3_legal(funct3, mem_we) && f3_aligned(funct3, addr[1:0]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    // Result and error flags live for the single DONE cycle only.
    rdata_d     = '0;
    mis_d       = 1'b0;
    bus_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_we || mem_re) begin
          if (access_ok) begin
            we_d        = mem_we;
            f3_d        = funct3;
            lo_d        = addr[1:0];
            req_addr_d  = {addr[31:2], 2'b00};
            req_wdata_d = mem_we ? st_lane_data : '0;
            req_wstrb_d = mem_we ? st_lane_strb : '0;
            cnt_d       = '0;
            state_d     = S_REQ;
          end else begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (req_ready) begin
          cnt_d   = '0;
          state_d = we_q ? S_DONE : S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          bus_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_valid) begin
          rdata_d = ld_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      lo_q        <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      rdata_q     <= '0;
      mis_q       <= 1'b0;
      bus_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
      bus_q       <= bus_d;
    end
  end

  // The core advances on the edge that ends DONE, so stall drops there.
  assign stall        = (mem_re || mem_we) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign req_valid    = (state_q == S_REQ);
  assign req_we       = we_q;
  assign req_addr     = req_addr_q;
  assign req_wdata    = req_wdata_q;
  assign req_wstrb    = req_wstrb_q;
  assign rdata        = rdata_q;
  assign misalign_err = mis_q;
  assign bus_err      = bus_q;

endmodule
